aes_rcon_seq: RTL and testbench

//  Sequential AES key-schedule round-constant generator; replaces table lookup with iterated xtime.

---
 rtl/aes_rcon_seq.sv | 114 +++++++++++
 tb/tb_aes_rcon_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/aes_rcon_seq.sv
// Sequential AES round-constant generator: emits INIT, xtime(INIT), ... one value per
// accepted handshake, with the sequence length chosen by the mode latched at start.
module aes_rcon_seq #(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     POLY  = 8'h1b,
  parameter logic [WIDTH-1:0]     INIT  = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             next,
  output logic             rcon_valid,
  output logic [WIDTH-1:0] rcon_out,
  output logic [3:0]       rcon_idx,
  output logic             rcon_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             valid_d, last_d, busy_d, done_d;
  logic [WIDTH-1:0] out_d;
  logic [3:0]       idx_d;

  // Multiply by x in GF(2^WIDTH), reducing by POLY when the top bit shifts out.
  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] r);
    return {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? POLY : '0);
  endfunction

  function automatic logic [3:0] count_for(input logic [1:0] m);
    case (m)
      2'b00:   return 4'd10;
      2'b01:   return 4'd8;
      2'b10:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    state_d = state_q;
    mode_d  = mode_q;
    valid_d = rcon_valid;
    out_d   = rcon_out;
    idx_d   = rcon_idx;
    busy_d  = busy;
    done_d  = 1'b0;

    if (start) begin
      // Restart from any state; a simultaneous next is deliberately dropped.
      state_d = RUN;
      mode_d  = mode;
      valid_d = 1'b1;
      out_d   = INIT;
      idx_d   = 4'd1;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (rcon_valid && next) begin
            if (rcon_last) begin
              state_d = DONE;
              valid_d = 1'b0;
              out_d   = '0;
              idx_d   = 4'd0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              out_d = xtime(rcon_out);
              idx_d = rcon_idx + 4'd1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Registered so rcon_last is glitch-free and aligned with rcon_idx.
    last_d = valid_d && (idx_d == count_for(mode_d));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= 2'b00;
      rcon_valid <= 1'b0;
      rcon_out   <= '0;
      rcon_idx   <= 4'd0;
      rcon_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rcon_valid <= valid_d;
      rcon_out   <= out_d;
      rcon_idx   <= idx_d;
      rcon_last  <= last_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Directed bench for aes_rcon_seq: reset, full runs per mode, stalled handshakes,
// restart mid-sequence and reset mid-sequence, against a hand-written constant table.
module tb_aes_rcon_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       next;
  logic       rcon_valid;
  logic [7:0] rcon_out;
  logic [3:0] rcon_idx;
  logic       rcon_last;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_tab [15];

  aes_rcon_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .next       (next),
    .rcon_valid (rcon_valid),
    .rcon_out   (rcon_out),
    .rcon_idx   (rcon_idx),
    .rcon_last  (rcon_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(rcon_valid), 32'd0);
    check({tag, "_out"},   32'(rcon_out),   32'd0);
    check({tag, "_idx"},   32'(rcon_idx),   32'd0);
    check({tag, "_last"},  32'(rcon_last),  32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  task automatic check_const(input string tag, input int i, input int n);
    check({tag, "_valid"}, 32'(rcon_valid), 32'd1);
    check({tag, "_out"},   32'(rcon_out),   32'(exp_tab[i]));
    check({tag, "_idx"},   32'(rcon_idx),   32'(i + 1));
    check({tag, "_last"},  32'(rcon_last),  32'(i == n - 1));
    check({tag, "_busy"},  32'(busy),       32'd1);
    check({tag, "_done"},  32'(done),       32'd0);
  endtask

  task automatic check_done_pulse(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check_idle(tag);
    next = 1'b1;  // next in IDLE must be ignored
    step();
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check_idle({tag, "_after"});
    next = 1'b0;
  endtask

  // Start in mode m with next held high; all n constants accepted back to back.
  task automatic run_full(input string tag, input logic [1:0] m, input int n);
    mode  = m;
    start = 1'b1;
    next  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check_const(tag, i, n);
      step();
    end
    check_done_pulse(tag);
  endtask

  initial begin
    exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d, 8'h9a};
    rst = 1'b1; start = 1'b1; mode = 2'b11; next = 1'b1;

    // Reset held two cycles while start/next toggle.
    step();
    check_idle("rst1");
    check("rst1_done", 32'(done), 32'd0);
    start = 1'b0; next = 1'b0;
    step();
    check_idle("rst2");
    check("rst2_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    check_idle("idle");

    // AES-128 and full-table runs.
    run_full("m00", 2'b00, 10);
    run_full("m11", 2'b11, 15);

    // AES-256 with next every third cycle; mode change after start has no effect.
    mode = 2'b10; start = 1'b1;
    step();
    start = 1'b0; mode = 2'b00;
    for (int i = 0; i < 7; i++) begin
      for (int h = 0; h < 2; h++) begin
        next = 1'b0;
        check_const("m10_hold", i, 7);
        step();
      end
      check_const("m10_acc", i, 7);
      next = 1'b1;
      step();
    end
    next = 1'b0;
    check_done_pulse("m10");

    // AES-192, restart at idx 5 with next also high.
    mode = 2'b01; start = 1'b1; next = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_const("m01_pre", 4, 8);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_const("m01_rs", i, 8);
      step();
    end
    check_done_pulse("m01");

    // Reset at idx 6 overrides start/next; no done pulse follows.
    mode = 2'b00; start = 1'b1; next = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_const("rstmid_pre", 5, 10);
    rst = 1'b1; start = 1'b1;
    step();
    check_idle("rstmid");
    check("rstmid_done", 32'(done), 32'd0);
    rst = 1'b0; start = 1'b0;
    step();
    check_idle("rstmid_after");
    check("rstmid_after_done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
